// File: rtl/mul_pkg.sv
// Shared encodings for the RV32M multiply sequencer: op codes, FSM states and
// the default word width.
package mul_pkg;

  localparam int MUL_XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  function automatic logic rs1_is_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic rs2_is_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_rca_nbit.sv
// Parameterised ripple-carry adder built from a chain of full-adder cells.
module rca_nbit #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add sequencer for MUL/MULH/MULHSU/MULHU, one partial product per cycle.
// Optional macro MUL_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are zero.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mul_state_e        state, state_nxt;
  logic [XLEN-1:0]   mcand, mplier, acc_hi;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [1:0]        op_q;
  logic              early_exit;
  logic [XLEN:0]     add_a, add_b, add_sum;
  logic              add_cout;
  logic [2*XLEN-1:0] prod, prod_fix;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    logic signed [XLEN-1:0] v_s;
    v_s = v;
    return (is_signed && v_s < 0) ? XLEN'(-v_s) : v;
  endfunction

  assign add_a = {1'b0, acc_hi};
  assign add_b = mplier[0] ? {1'b0, mcand} : '0;

  rca_nbit #(.WIDTH(XLEN + 1)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign prod     = {acc_hi, mplier};
  assign prod_fix = neg ? -prod : prod;

`ifdef MUL_EARLY_EXIT_EN
  logic [XLEN-1:0]   unproc_mask;
  logic [CNT_W:0]    shamt;
  logic [2*XLEN-1:0] prod_skip;

  // mplier[cnt:0] still holds multiplier bits; everything above is product.
  assign unproc_mask = {XLEN{1'b1}} >> (CNT_W'(XLEN - 1) - cnt);
  assign early_exit  = ~|(mplier & unproc_mask);
  assign shamt       = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign prod_skip   = prod >> shamt;
`else
  assign early_exit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) state_nxt = ST_CALC;
        ST_CALC: if (cnt == '0 || early_exit) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc_hi     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      op_q       <= MUL_OP_MUL;
      result     <= '0;
      resp_valid <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mcand  <= mag(rs1, rs1_is_signed(op));
            mplier <= mag(rs2, rs2_is_signed(op));
            neg    <= (rs1_is_signed(op) & rs1[XLEN-1]) ^ (rs2_is_signed(op) & rs2[XLEN-1]);
            acc_hi <= '0;
            cnt    <= CNT_W'(XLEN - 1);
            op_q   <= op;
          end
        end
        ST_CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          if (early_exit) begin
            {acc_hi, mplier} <= prod_skip;
            cnt              <= '0;
          end else
`endif
          begin
            // Carry-out cannot be set: both addends are zero-extended by one bit.
            acc_hi <= {add_sum[XLEN] | add_cout, add_sum[XLEN-1:1]};
            mplier <= {add_sum[0], mplier[XLEN-1:1]};
            cnt    <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          result     <= (op_q == MUL_OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          resp_valid <= 1'b1;
        end
        ST_DONE: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; expected latencies follow MUL_EARLY_EXIT_EN.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  localparam int XLEN = 32;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      op = MUL_OP_MUL;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  // Accept one request, scramble operands, wait for the response and consume it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    int busy_cnt;
    req_valid  = 1'b1;
    op         = o;
    rs1        = a;
    rs2        = b;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    op  = 2'($urandom_range(0, 3));
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    check_eq({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat));
    tick();
    check_eq({tag, "_idle"}, {29'd0, busy, resp_valid, req_ready}, 32'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;

    tick();
    tick();
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    run_op("mul_7x6",        MUL_OP_MUL,    32'd7,        32'd6,        32'h0000002A, lat(34, 6));
    run_op("mulh_min",       MUL_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu_min",      MUL_OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mul_min",        MUL_OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 34);
    run_op("mulhsu_m1",      MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("mulh_m1",        MUL_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, lat(34, 4));
    run_op("mul_5x0",        MUL_OP_MUL,    32'd5,        32'd0,        32'h00000000, lat(34, 3));
    run_op("mul_5x3",        MUL_OP_MUL,    32'd5,        32'd3,        32'h0000000F, lat(34, 5));
    run_op("mul_m2x3",       MUL_OP_MUL,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, lat(34, 5));
    run_op("mulh_m2x3",      MUL_OP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, lat(34, 5));

    // Backpressure in DONE
    req_valid  = 1'b1;
    op         = MUL_OP_MUL;
    rs1        = 32'd3;
    rs2        = 32'd4;
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq("bp_res", result, 32'd12);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_hold", {29'd0, resp_valid, req_ready, busy}, 32'b101);
      check_eq("bp_hold_res", result, 32'd12);
    end
    resp_ready = 1'b1;
    tick();
    check_eq("bp_release", {29'd0, resp_valid, req_ready, busy}, 32'b010);

    // Flush ten cycles after accept; multiplier MSB set so no early exit is possible
    req_valid = 1'b1;
    op        = MUL_OP_MUL;
    rs1       = 32'd9;
    rs2       = 32'h80000001;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    check_eq("fl_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_idle", {29'd0, busy, resp_valid, req_ready}, 32'b001);
    check_eq("fl_res_kept", result, 32'd12);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (resp_valid || busy) seen = 1'b1;
    end
    check_eq("fl_no_resp", {31'd0, seen}, 32'd0);

    // Flush concurrent with a request in IDLE
    req_valid = 1'b1;
    flush     = 1'b1;
    rs1       = 32'd2;
    rs2       = 32'd2;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq("flreq_no_accept", {31'd0, busy}, 32'd0);
    tick();
    check_eq("flreq_still_idle", {30'd0, busy, req_ready}, 32'b01);

    // Asynchronous reset in the middle of CALC
    req_valid = 1'b1;
    op        = MUL_OP_MULHU;
    rs1       = 32'hFFFFFFFF;
    rs2       = 32'h80000001;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check_eq("rr_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rr_result", result, 32'h0);
    check_eq("rr_flags", {29'd0, busy, resp_valid, req_ready}, 32'b001);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst", MUL_OP_MUL, 32'd7, 32'd6, 32'h0000002A, lat(34, 6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
